// File: rtl/mem_1w1r_fifo_ctrl.sv
// Valid/ready FIFO sequencer around an external mem_1w1r with a 1-cycle registered read.
// Define MEM_FIFO_LEVEL_EN to add the level_o / almost_full_o outputs.
module mem_1w1r_fifo_ctrl #(
  parameter int unsigned ELEMENTS_W  = 7,
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned ALMOST_FULL = 6
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [WIDTH-1:0]      in_data_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [WIDTH-1:0]      out_data_o,
  output logic                  mem_read_o,
  output logic [ELEMENTS_W-1:0] mem_raddr_o,
  output logic                  mem_write_o,
  output logic [ELEMENTS_W-1:0] mem_waddr_o,
  output logic [WIDTH-1:0]      mem_wdata_o,
  input  logic [WIDTH-1:0]      mem_readdata_i
`ifdef MEM_FIFO_LEVEL_EN
  ,
  output logic [ELEMENTS_W:0]   level_o,
  output logic                  almost_full_o
`endif
);

  localparam logic [ELEMENTS_W:0] Capacity = {1'b1, {ELEMENTS_W{1'b0}}};

  logic [ELEMENTS_W:0] wptr_q, wptr_d;
  logic [ELEMENTS_W:0] rptr_q, rptr_d;
  logic                out_valid_q, out_valid_d;
  logic [ELEMENTS_W:0] stored;
  logic                full, empty;

  always_comb begin
    stored = wptr_q - rptr_q;
    full   = (stored == Capacity);
    empty  = (stored == '0);
  end

  always_comb begin
    in_ready_o  = !full && !flush_i;
    // Gated by reset so an in-progress burst stops writing the moment reset is applied.
    mem_write_o = in_valid_i && in_ready_o && !rst_i;
    mem_read_o  = !empty && (!out_valid_q || out_ready_i) && !flush_i;
    mem_waddr_o = wptr_q[ELEMENTS_W-1:0];
    mem_raddr_o = rptr_q[ELEMENTS_W-1:0];
    mem_wdata_o = in_data_i;
    out_data_o  = mem_readdata_i;
    out_valid_o = out_valid_q;
  end

  always_comb begin
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    out_valid_d = out_valid_q;
    if (flush_i) begin
      wptr_d      = '0;
      rptr_d      = '0;
      out_valid_d = 1'b0;
    end else begin
      wptr_d      = wptr_q + {{ELEMENTS_W{1'b0}}, mem_write_o};
      rptr_d      = rptr_q + {{ELEMENTS_W{1'b0}}, mem_read_o};
      out_valid_d = mem_read_o || (out_valid_q && !out_ready_i);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      out_valid_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      out_valid_q <= out_valid_d;
    end
  end

`ifdef MEM_FIFO_LEVEL_EN
  always_comb begin
    level_o       = stored + {{ELEMENTS_W{1'b0}}, out_valid_q};
    almost_full_o = 32'(level_o) >= ALMOST_FULL;
  end
`endif

endmodule

// File: tb/tb_mem_1w1r_fifo_ctrl.sv
// Scoreboard bench for mem_1w1r_fifo_ctrl with a behavioural mem_1w1r model.
// Level checks are compiled in only when MEM_FIFO_LEVEL_EN is defined.
module tb_mem_1w1r_fifo_ctrl;

  localparam int unsigned EW = 2;
  localparam int unsigned W  = 8;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          flush_i;
  logic          in_valid_i;
  logic          in_ready_o;
  logic [W-1:0]  in_data_i;
  logic          out_valid_o;
  logic          out_ready_i;
  logic [W-1:0]  out_data_o;
  logic          mem_read_o;
  logic [EW-1:0] mem_raddr_o;
  logic          mem_write_o;
  logic [EW-1:0] mem_waddr_o;
  logic [W-1:0]  mem_wdata_o;
  logic [W-1:0]  mem_readdata_i;
`ifdef MEM_FIFO_LEVEL_EN
  logic [EW:0]   level_o;
  logic          almost_full_o;
`endif

  int errors = 0;
  int checks = 0;
  logic [W-1:0] sb_q[$];
  logic [W-1:0] mem [4];

  always #5 clk_i = ~clk_i;

  mem_1w1r_fifo_ctrl #(
    .ELEMENTS_W (EW),
    .WIDTH      (W),
    .ALMOST_FULL(4)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .flush_i       (flush_i),
    .in_valid_i    (in_valid_i),
    .in_ready_o    (in_ready_o),
    .in_data_i     (in_data_i),
    .out_valid_o   (out_valid_o),
    .out_ready_i   (out_ready_i),
    .out_data_o    (out_data_o),
    .mem_read_o    (mem_read_o),
    .mem_raddr_o   (mem_raddr_o),
    .mem_write_o   (mem_write_o),
    .mem_waddr_o   (mem_waddr_o),
    .mem_wdata_o   (mem_wdata_o),
    .mem_readdata_i(mem_readdata_i)
`ifdef MEM_FIFO_LEVEL_EN
    ,
    .level_o       (level_o),
    .almost_full_o (almost_full_o)
`endif
  );

  // Behavioural mem_1w1r: synchronous write, registered read.
  always @(posedge clk_i) begin
    if (mem_write_o) mem[mem_waddr_o] <= mem_wdata_o;
    if (mem_read_o) mem_readdata_i <= mem[mem_raddr_o];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Scoreboard: record accepted pushes, compare every accepted pop in order.
  always @(negedge clk_i) begin
    if (rst_i || flush_i) begin
      sb_q.delete();
    end else begin
      if (out_valid_o && out_ready_i) begin
        if (sb_q.size() == 0) begin
          chk("pop_with_empty_scoreboard", 32'(out_data_o), 32'hFFFF_FFFF);
        end else begin
          chk("pop_order", 32'(out_data_o), 32'(sb_q.pop_front()));
        end
      end
      if (in_valid_i && in_ready_o) sb_q.push_back(in_data_i);
    end
  end

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk_level(input string nm, input int lvl, input logic af);
`ifdef MEM_FIFO_LEVEL_EN
    chk({nm, "_level"}, 32'(level_o), 32'(lvl));
    chk({nm, "_almost_full"}, 32'(almost_full_o), 32'(af));
`else
    if (lvl < 0 || af === 1'bx) $display("bad level argument in %s", nm);
`endif
  endtask

  initial begin
    rst_i       = 1'b1;
    flush_i     = 1'b0;
    in_valid_i  = 1'b1;
    in_data_i   = 8'hA5;
    out_ready_i = 1'b0;

    // Reset state, with in_valid already high.
    @(negedge clk_i);
    chk("rst_in_ready", 32'(in_ready_o), 32'd1);
    chk("rst_out_valid", 32'(out_valid_o), 32'd0);
    chk("rst_mem_read", 32'(mem_read_o), 32'd0);
    chk("rst_mem_write", 32'(mem_write_o), 32'd0);
    chk_level("rst", 0, 1'b0);
    next_cycle();
    rst_i = 1'b0;

    // Single push of 0xA5: read fetch one cycle later, output the cycle after.
    @(negedge clk_i);
    chk("t1_mem_write", 32'(mem_write_o), 32'd1);
    next_cycle();
    in_valid_i = 1'b0;
    @(negedge clk_i);
    chk("t1_mem_read", 32'(mem_read_o), 32'd1);
    chk("t1_out_valid_early", 32'(out_valid_o), 32'd0);
    next_cycle();

    // Output hold with out_ready low for three cycles.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      chk("t4_out_valid", 32'(out_valid_o), 32'd1);
      chk("t4_out_data", 32'(out_data_o), 32'hA5);
      chk("t4_mem_read", 32'(mem_read_o), 32'd0);
      next_cycle();
    end
    out_ready_i = 1'b1;
    next_cycle();
    out_ready_i = 1'b0;
    @(negedge clk_i);
    chk("t1_out_valid_after_pop", 32'(out_valid_o), 32'd0);
    next_cycle();

    // Fill: 0x01..0x07 offered with out_ready low, only the first five fit.
    for (int k = 0; k < 7; k++) begin
      in_valid_i = 1'b1;
      in_data_i  = 8'(k + 1);
      @(negedge clk_i);
      chk("t2_in_ready", 32'(in_ready_o), 32'(k < 5));
      if (k == 5) chk_level("t2_full", 5, 1'b1);
      next_cycle();
    end
    in_valid_i  = 1'b0;
    out_ready_i = 1'b1;
    repeat (8) next_cycle();
    @(negedge clk_i);
    chk("t2_drained_out_valid", 32'(out_valid_o), 32'd0);
    chk("t2_drained_scoreboard", 32'(sb_q.size()), 32'd0);
    next_cycle();

    // Streaming: one word per cycle with no bubbles once output starts.
    for (int i = 0; i < 20; i++) begin
      in_valid_i = 1'b1;
      in_data_i  = 8'(8'h10 + i);
      @(negedge clk_i);
      chk("t3_mem_write", 32'(mem_write_o), 32'd1);
      if (i >= 2) chk("t3_out_valid", 32'(out_valid_o), 32'd1);
      next_cycle();
    end
    in_valid_i = 1'b0;
    repeat (4) next_cycle();
    @(negedge clk_i);
    chk("t3_drained_scoreboard", 32'(sb_q.size()), 32'd0);
    next_cycle();

    // Flush with in_valid high after three entries.
    out_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid_i = 1'b1;
      in_data_i  = 8'(8'h30 + i);
      next_cycle();
    end
    flush_i   = 1'b1;
    in_data_i = 8'hEE;
    @(negedge clk_i);
    chk("t5_flush_mem_write", 32'(mem_write_o), 32'd0);
    chk("t5_flush_mem_read", 32'(mem_read_o), 32'd0);
    chk("t5_flush_in_ready", 32'(in_ready_o), 32'd0);
    next_cycle();
    flush_i    = 1'b0;
    in_valid_i = 1'b0;
    @(negedge clk_i);
    chk("t5_out_valid", 32'(out_valid_o), 32'd0);
    chk("t5_in_ready", 32'(in_ready_o), 32'd1);
    chk("t5_mem_read", 32'(mem_read_o), 32'd0);
    chk_level("t5", 0, 1'b0);
    next_cycle();

    // Asynchronous reset in the middle of a push/pop burst.
    out_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid_i = 1'b1;
      in_data_i  = 8'(8'h50 + i);
      next_cycle();
    end
    #2;
    rst_i = 1'b1;
    #1;
    chk("t6_out_valid", 32'(out_valid_o), 32'd0);
    chk("t6_mem_read", 32'(mem_read_o), 32'd0);
    chk("t6_mem_write", 32'(mem_write_o), 32'd0);
    next_cycle();
    rst_i      = 1'b0;
    in_valid_i = 1'b0;
    @(negedge clk_i);
    chk("t6_after_out_valid", 32'(out_valid_o), 32'd0);
    chk("t6_after_in_ready", 32'(in_ready_o), 32'd1);
    chk_level("t6_after", 0, 1'b0);
    next_cycle();
    in_valid_i = 1'b1;
    in_data_i  = 8'h77;
    next_cycle();
    in_valid_i = 1'b0;
    repeat (4) next_cycle();
    @(negedge clk_i);
    chk("final_scoreboard", 32'(sb_q.size()), 32'd0);
    chk("final_out_valid", 32'(out_valid_o), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
